lsu_mem: RTL and testbench

//  MEM stage of the riscvBoy 5-stage core. It consumes the registered EX/MEM load/store request and drives a

---
 rtl/lsu_mem_pkg.sv | 29 ++
 rtl/lsu_mem_if.sv | 22 ++
 rtl/lsu_mem_align.sv | 48 ++++
 rtl/lsu_mem.sv | 145 ++++++++++++++
 tb/tb_lsu_mem.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 size/sign codes,
// FSM states and the access legality rule.
package lsu_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  // Unknown size codes and accesses that straddle their natural alignment are dropped.
  function automatic logic access_illegal(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Data-bus bundle between the MEM stage and memory: a single-outstanding
// valid/ready request channel plus a response strobe used by reads and writes.
interface lsu_mem_if;
  logic        o_dbus_req_vld;
  logic        i_dbus_req_rdy;
  logic [31:0] o_dbus_addr;
  logic        o_dbus_we;
  logic [3:0]  o_dbus_wstrb;
  logic [31:0] o_dbus_wdata;
  logic        i_dbus_rsp_vld;
  logic [31:0] i_dbus_rdata;

  modport master (
    output o_dbus_req_vld, o_dbus_addr, o_dbus_we, o_dbus_wstrb, o_dbus_wdata,
    input  i_dbus_req_rdy, i_dbus_rsp_vld, i_dbus_rdata
  );

  modport slave (
    input  o_dbus_req_vld, o_dbus_addr, o_dbus_we, o_dbus_wstrb, o_dbus_wdata,
    output i_dbus_req_rdy, i_dbus_rsp_vld, i_dbus_rdata
  );
endinterface

// File: rtl/lsu_mem_align.sv
// Combinational lane logic: store byte strobes and lane replication, and load
// byte/half extraction with sign or zero extension.
module lsu_mem_align
  import lsu_mem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    st_wstrb = 4'hF;
    st_wdata = st_data;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_wstrb = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        st_wstrb = 4'b0011 << st_addr_lo;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shift = ld_rdata >> {ld_addr_lo, 3'b000};
    ld_data  = ld_shift;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_BU:   ld_data = {24'h0, ld_shift[7:0]};
      F3_HU:   ld_data = {16'h0, ld_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// MEM stage: drives one data-bus transaction at a time, stalls the front end
// while it is pending, and registers the MEM/WB writeback.
module lsu_mem
  import lsu_mem_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             i_mem_wreq,
  input  logic             i_mem_rreq,
  input  logic [31:0]      i_mem_addr,
  input  logic [31:0]      i_mem_wdata,
  input  logic [2:0]       i_mem_funct3,
  input  logic             i_rd_wen,
  input  logic [4:0]       i_rd_addr,
  input  logic [31:0]      i_result,
  output logic             o_stall,
  output logic             o_misalign,
  output logic             o_bus_err,
  lsu_mem_if.master        dbus,
  output logic             o_rd_wen,
  output logic [4:0]       o_rd_addr,
  output logic [31:0]      o_rd_wdata
);

  state_e      state;
  logic [31:0] cnt;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_addr_lo;
  logic        cap_rd_wen;
  logic [4:0]  cap_rd_addr;

  logic        req_any;
  logic        illegal;
  logic        timeout;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign req_any = i_mem_wreq | i_mem_rreq;
  assign illegal = access_illegal(i_mem_funct3, i_mem_addr[1:0]);
  assign timeout = (RSP_TIMEOUT != 0) && (state != S_IDLE) && (cnt == RSP_TIMEOUT - 1);

  lsu_mem_align u_align (
    .st_funct3  (i_mem_funct3),
    .st_addr_lo (i_mem_addr[1:0]),
    .st_data    (i_mem_wdata),
    .st_wstrb   (st_wstrb),
    .st_wdata   (st_wdata),
    .ld_funct3  (cap_funct3),
    .ld_addr_lo (cap_addr_lo),
    .ld_rdata   (dbus.i_dbus_rdata),
    .ld_data    (ld_data)
  );

  // The stall releases in the completing cycle so the next op is presented right after the response.
  always_comb begin
    o_stall = 1'b0;
    case (state)
      S_IDLE:  o_stall = req_any & ~illegal;
      S_REQ:   o_stall = ~timeout;
      S_RESP:  o_stall = ~(dbus.i_dbus_rsp_vld | timeout);
      default: o_stall = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      cap_funct3          <= '0;
      cap_addr_lo         <= '0;
      cap_rd_wen          <= 1'b0;
      cap_rd_addr         <= '0;
      o_misalign          <= 1'b0;
      o_bus_err           <= 1'b0;
      dbus.o_dbus_req_vld <= 1'b0;
      dbus.o_dbus_addr    <= '0;
      dbus.o_dbus_we      <= 1'b0;
      dbus.o_dbus_wstrb   <= '0;
      dbus.o_dbus_wdata   <= '0;
      o_rd_wen            <= 1'b0;
      o_rd_addr           <= '0;
      o_rd_wdata          <= '0;
    end else begin
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!req_any) begin
            o_rd_wen   <= i_rd_wen;
            o_rd_addr  <= i_rd_addr;
            o_rd_wdata <= i_result;
          end else if (illegal) begin
            o_misalign <= 1'b1;
            o_rd_wen   <= 1'b0;
          end else begin
            // A store wins over a simultaneous load, so it never writes back.
            cap_funct3          <= i_mem_funct3;
            cap_addr_lo         <= i_mem_addr[1:0];
            cap_rd_wen          <= i_rd_wen & ~i_mem_wreq;
            cap_rd_addr         <= i_rd_addr;
            dbus.o_dbus_req_vld <= 1'b1;
            dbus.o_dbus_addr    <= {i_mem_addr[31:2], 2'b00};
            dbus.o_dbus_we      <= i_mem_wreq;
            dbus.o_dbus_wstrb   <= i_mem_wreq ? st_wstrb : 4'h0;
            dbus.o_dbus_wdata   <= st_wdata;
            o_rd_wen            <= 1'b0;
            state               <= S_REQ;
          end
        end
        S_REQ: begin
          cnt <= cnt + 32'd1;
          if (timeout) begin
            dbus.o_dbus_req_vld <= 1'b0;
            o_bus_err           <= 1'b1;
            o_rd_wen            <= 1'b0;
            state               <= S_IDLE;
          end else if (dbus.i_dbus_req_rdy) begin
            dbus.o_dbus_req_vld <= 1'b0;
            state               <= S_RESP;
          end
        end
        S_RESP: begin
          cnt <= cnt + 32'd1;
          if (dbus.i_dbus_rsp_vld) begin
            o_rd_wen  <= cap_rd_wen;
            o_rd_addr <= cap_rd_addr;
            if (!dbus.o_dbus_we) o_rd_wdata <= ld_data;
            state <= S_IDLE;
          end else if (timeout) begin
            o_bus_err <= 1'b1;
            o_rd_wen  <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: hand-computed vector table, randomized ops checked against
// a size/offset reference model, and hand sequences for timeout and reset.
module tb_lsu_mem;

  localparam int unsigned TIMEOUT = 8;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        i_mem_wreq, i_mem_rreq;
  logic [31:0] i_mem_addr, i_mem_wdata;
  logic [2:0]  i_mem_funct3;
  logic        i_rd_wen;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_result;
  logic        o_stall, o_misalign, o_bus_err, o_rd_wen;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_wdata;

  lsu_mem_if dbus ();

  lsu_mem #(.RSP_TIMEOUT(TIMEOUT)) dut (
    .clk_sys      (clk_sys),
    .rst_sys      (rst_sys),
    .i_mem_wreq   (i_mem_wreq),
    .i_mem_rreq   (i_mem_rreq),
    .i_mem_addr   (i_mem_addr),
    .i_mem_wdata  (i_mem_wdata),
    .i_mem_funct3 (i_mem_funct3),
    .i_rd_wen     (i_rd_wen),
    .i_rd_addr    (i_rd_addr),
    .i_result     (i_result),
    .o_stall      (o_stall),
    .o_misalign   (o_misalign),
    .o_bus_err    (o_bus_err),
    .dbus         (dbus),
    .o_rd_wen     (o_rd_wen),
    .o_rd_addr    (o_rd_addr),
    .o_rd_wdata   (o_rd_wdata)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    bit          wr;
    bit          rd;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          rd_wen;
    logic [4:0]  rd_a;
    int          rdy_dly;
    int          rsp_dly;
    bit          x_mis;
    logic [3:0]  x_wstrb;
    logic [31:0] x_bwdata;
    bit          x_rd_wen;
    logic [31:0] x_rd_wdata;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [16];
  vec_t rv;
  logic [2:0] ld_f3s [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7, 3'd1};

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic scramble();
    i_mem_wreq   = 1'b0;
    i_mem_rreq   = 1'b0;
    i_mem_addr   = $urandom;
    i_mem_wdata  = $urandom;
    i_mem_funct3 = 3'($urandom);
    i_rd_wen     = 1'($urandom);
    i_rd_addr    = 5'($urandom);
    i_result     = $urandom;
  endtask

  function automatic vec_t mk(bit wr, bit rd, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, bit rdw, logic [4:0] rda, int rdy, int rsp, bit mis,
                              logic [3:0] ws, logic [31:0] bwd, bit xw, logic [31:0] xd);
    vec_t r;
    r = '0;
    r.wr = wr; r.rd = rd; r.f3 = f3; r.addr = addr; r.wdata = wdata; r.rdata = rdata;
    r.rd_wen = rdw; r.rd_a = rda; r.rdy_dly = rdy; r.rsp_dly = rsp;
    r.x_mis = mis; r.x_wstrb = ws; r.x_bwdata = bwd; r.x_rd_wen = xw; r.x_rd_wdata = xd;
    return r;
  endfunction

  // Reference: access size in bytes and byte offset, computed arithmetically.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int unsigned off, size;
    bit          uns;
    logic [31:0] mask, val;
    r = v;
    off = int'(v.addr[1:0]);
    uns = 1'b0;
    case (v.f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1'b1; end
      3'd5: begin size = 2; uns = 1'b1; end
      default: size = 0;
    endcase
    r.x_mis = (size == 0) || ((off % size) != 0);
    r.x_wstrb = '0; r.x_bwdata = '0; r.x_rd_wen = 1'b0; r.x_rd_wdata = '0;
    if (r.x_mis) return r;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (v.wr) begin
      r.x_wstrb  = 4'(((1 << size) - 1) << off);
      r.x_bwdata = (size == 1) ? (v.wdata & mask) * 32'h0101_0101 :
                   (size == 2) ? (v.wdata & mask) * 32'h0001_0001 : v.wdata;
    end else begin
      val = (v.rdata >> (8 * off)) & mask;
      if (!uns && size < 4 && val[8*size-1]) val = val | ~mask;
      r.x_rd_wen   = v.rd_wen;
      r.x_rd_wdata = val;
    end
    return r;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    i_mem_wreq = v.wr; i_mem_rreq = v.rd; i_mem_funct3 = v.f3; i_mem_addr = v.addr;
    i_mem_wdata = v.wdata; i_rd_wen = v.rd_wen; i_rd_addr = v.rd_a; i_result = $urandom;
    dbus.i_dbus_req_rdy = 1'b0;
    dbus.i_dbus_rsp_vld = 1'b0;
    #1;
    check($sformatf("%s.stall_accept", tag), o_stall, !v.x_mis);
    check($sformatf("%s.vld_accept", tag), dbus.o_dbus_req_vld, 0);
    tick();
    scramble();
    if (v.x_mis) begin
      #1;
      check($sformatf("%s.misalign", tag), o_misalign, 1);
      check($sformatf("%s.mis_rd_wen", tag), o_rd_wen, 0);
      check($sformatf("%s.mis_vld", tag), dbus.o_dbus_req_vld, 0);
      check($sformatf("%s.mis_stall", tag), o_stall, 0);
      tick();
      check($sformatf("%s.misalign_pulse", tag), o_misalign, 0);
      return;
    end
    for (int k = 0; k <= v.rdy_dly; k++) begin
      dbus.i_dbus_req_rdy = (k == v.rdy_dly);
      #1;
      check($sformatf("%s.req_vld[%0d]", tag, k), dbus.o_dbus_req_vld, 1);
      check($sformatf("%s.addr[%0d]", tag, k), dbus.o_dbus_addr, {v.addr[31:2], 2'b00});
      check($sformatf("%s.we[%0d]", tag, k), dbus.o_dbus_we, v.wr);
      check($sformatf("%s.wstrb[%0d]", tag, k), dbus.o_dbus_wstrb, v.x_wstrb);
      if (v.wr) check($sformatf("%s.wdata[%0d]", tag, k), dbus.o_dbus_wdata, v.x_bwdata);
      check($sformatf("%s.stall_req[%0d]", tag, k), o_stall, 1);
      tick();
    end
    dbus.i_dbus_req_rdy = 1'b0;
    for (int k = 0; k <= v.rsp_dly; k++) begin
      dbus.i_dbus_rsp_vld = (k == v.rsp_dly);
      dbus.i_dbus_rdata   = (k == v.rsp_dly) ? v.rdata : $urandom;
      #1;
      check($sformatf("%s.vld_resp[%0d]", tag, k), dbus.o_dbus_req_vld, 0);
      check($sformatf("%s.stall_resp[%0d]", tag, k), o_stall, (k != v.rsp_dly));
      tick();
    end
    dbus.i_dbus_rsp_vld = 1'b0;
    check($sformatf("%s.rd_wen", tag), o_rd_wen, v.x_rd_wen);
    if (!v.wr) begin
      check($sformatf("%s.rd_addr", tag), o_rd_addr, v.rd_a);
      check($sformatf("%s.rd_wdata", tag), o_rd_wdata, v.x_rd_wdata);
    end
    check($sformatf("%s.bus_err", tag), o_bus_err, 0);
  endtask

  task automatic passthrough(input string tag, input bit wen, input logic [4:0] a, input logic [31:0] d);
    scramble();
    i_rd_wen = wen; i_rd_addr = a; i_result = d;
    #1;
    check($sformatf("%s.stall", tag), o_stall, 0);
    tick();
    check($sformatf("%s.rd_wen", tag), o_rd_wen, wen);
    check($sformatf("%s.rd_addr", tag), o_rd_addr, a);
    check($sformatf("%s.rd_wdata", tag), o_rd_wdata, d);
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s.stall", tag), o_stall, 0);
    check($sformatf("%s.misalign", tag), o_misalign, 0);
    check($sformatf("%s.bus_err", tag), o_bus_err, 0);
    check($sformatf("%s.req_vld", tag), dbus.o_dbus_req_vld, 0);
    check($sformatf("%s.addr", tag), dbus.o_dbus_addr, 0);
    check($sformatf("%s.we", tag), dbus.o_dbus_we, 0);
    check($sformatf("%s.wstrb", tag), dbus.o_dbus_wstrb, 0);
    check($sformatf("%s.wdata", tag), dbus.o_dbus_wdata, 0);
    check($sformatf("%s.rd_wen", tag), o_rd_wen, 0);
    check($sformatf("%s.rd_addr", tag), o_rd_addr, 0);
    check($sformatf("%s.rd_wdata", tag), o_rd_wdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected it to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          wr rd f3      addr          wdata         rdata         rdw rd  rdy rsp mis wstrb  bus_wdata     xw xd
    tbl[0]  = mk(0, 1, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FF01, 1, 5'd3,  0, 0, 0, 4'h0, 32'h0,        1, 32'hFFFF_FF80);
    tbl[1]  = mk(1, 0, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        1, 5'd4,  0, 0, 0, 4'hC, 32'hABCD_ABCD, 0, 32'h0);
    tbl[2]  = mk(0, 1, 3'b101, 32'h0000_0002, 32'h0,        32'hBEEF_0000, 1, 5'd9,  4, 0, 0, 4'h0, 32'h0,        1, 32'h0000_BEEF);
    tbl[3]  = mk(0, 1, 3'b010, 32'h0000_1001, 32'h0,        32'h0,        1, 5'd1,  0, 0, 1, 4'h0, 32'h0,        0, 32'h0);
    tbl[4]  = mk(1, 0, 3'b000, 32'h0000_0101, 32'h1234_565A, 32'h0,        0, 5'd2,  1, 2, 0, 4'h2, 32'h5A5A_5A5A, 0, 32'h0);
    tbl[5]  = mk(1, 0, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        0, 5'd0,  0, 1, 0, 4'hF, 32'hDEAD_BEEF, 0, 32'h0);
    tbl[6]  = mk(0, 1, 3'b010, 32'h0000_2000, 32'h0,        32'h1234_5678, 1, 5'd31, 2, 1, 0, 4'h0, 32'h0,        1, 32'h1234_5678);
    tbl[7]  = mk(0, 1, 3'b001, 32'h0000_0006, 32'h0,        32'h8001_0000, 1, 5'd6,  0, 0, 0, 4'h0, 32'h0,        1, 32'hFFFF_8001);
    tbl[8]  = mk(0, 1, 3'b100, 32'h0000_0009, 32'h0,        32'h0000_9A00, 0, 5'd8,  0, 0, 0, 4'h0, 32'h0,        0, 32'h0000_009A);
    tbl[9]  = mk(0, 1, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        1, 5'd1,  0, 0, 1, 4'h0, 32'h0,        0, 32'h0);
    tbl[10] = mk(1, 0, 3'b001, 32'h0000_0001, 32'h0,        32'h0,        0, 5'd1,  0, 0, 1, 4'h0, 32'h0,        0, 32'h0);
    tbl[11] = mk(1, 1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 32'h0,        1, 5'd12, 0, 0, 0, 4'hF, 32'hCAFE_F00D, 0, 32'h0);
    tbl[12] = mk(0, 1, 3'b001, 32'h0000_0003, 32'h0,        32'h0,        1, 5'd1,  0, 0, 1, 4'h0, 32'h0,        0, 32'h0);
    tbl[13] = mk(0, 1, 3'b110, 32'h0000_0000, 32'h0,        32'h0,        1, 5'd1,  0, 0, 1, 4'h0, 32'h0,        0, 32'h0);
    tbl[14] = mk(0, 1, 3'b000, 32'h0000_0002, 32'h0,        32'h007F_0000, 1, 5'd14, 0, 2, 0, 4'h0, 32'h0,        1, 32'h0000_007F);
    tbl[15] = mk(1, 0, 3'b000, 32'h0000_0003, 32'h0000_00C3, 32'h0,        0, 5'd1,  2, 0, 0, 4'h8, 32'hC3C3_C3C3, 0, 32'h0);

    rst_sys = 1'b1;
    i_mem_wreq = 0; i_mem_rreq = 0; i_mem_addr = 0; i_mem_wdata = 0; i_mem_funct3 = 0;
    i_rd_wen = 0; i_rd_addr = 0; i_result = 0;
    dbus.i_dbus_req_rdy = 0; dbus.i_dbus_rsp_vld = 0; dbus.i_dbus_rdata = 0;
    tick();
    tick();
    check_zero("reset");
    rst_sys = 1'b0;

    passthrough("pass", 1'b1, 5'd5, 32'h0000_1234);

    for (int i = 0; i < 16; i++) run_op(tbl[i], $sformatf("v%0d", i));

    // Response never arrives: abort after TIMEOUT cycles in REQ+RESP, late response ignored.
    scramble();
    i_mem_rreq = 1'b1; i_mem_funct3 = 3'b010; i_mem_addr = 32'h40; i_rd_wen = 1'b1; i_rd_addr = 5'd7;
    #1;
    check("to.stall_accept", o_stall, 1);
    tick();
    scramble();
    for (int c = 0; c <= 9; c++) begin
      dbus.i_dbus_req_rdy = (c == 0);
      dbus.i_dbus_rsp_vld = (c == 9);
      dbus.i_dbus_rdata   = 32'hFFFF_FFFF;
      i_rd_wen = 1'b0;
      i_result = 32'h0000_600D;
      #1;
      if (c == 0) check("to.req_vld", dbus.o_dbus_req_vld, 1);
      if (c < 8)  check($sformatf("to.bus_err_low[%0d]", c), o_bus_err, 0);
      if (c <= 6) check($sformatf("to.stall[%0d]", c), o_stall, 1);
      if (c == 8) begin
        check("to.bus_err", o_bus_err, 1);
        check("to.vld_dropped", dbus.o_dbus_req_vld, 0);
        check("to.idle_stall", o_stall, 0);
        check("to.rd_wen", o_rd_wen, 0);
      end
      if (c == 9) check("to.bus_err_pulse", o_bus_err, 0);
      tick();
    end
    dbus.i_dbus_rsp_vld = 1'b0;
    check("to.late_rd_wen", o_rd_wen, 0);
    check("to.late_rd_wdata", o_rd_wdata, 32'h0000_600D);

    // Reset while waiting for a response abandons the access.
    passthrough("pre_rst", 1'b1, 5'd17, 32'hAAAA_5555);
    scramble();
    i_mem_rreq = 1'b1; i_mem_funct3 = 3'b010; i_mem_addr = 32'h3000; i_mem_wdata = 32'h1111_2222;
    i_rd_wen = 1'b1; i_rd_addr = 5'd20;
    tick();
    scramble();
    dbus.i_dbus_req_rdy = 1'b1;
    tick();
    dbus.i_dbus_req_rdy = 1'b0;
    #1;
    check("rst_mid.in_resp_stall", o_stall, 1);
    rst_sys = 1'b1;
    tick();
    check_zero("rst_mid");
    rst_sys = 1'b0;
    i_rd_wen = 1'b0;
    i_result = 32'h0000_0BAD;
    dbus.i_dbus_rsp_vld = 1'b1;
    dbus.i_dbus_rdata = 32'h1357_9BDF;
    #1;
    check("idle_rsp.stall", o_stall, 0);
    tick();
    dbus.i_dbus_rsp_vld = 1'b0;
    check("idle_rsp.rd_wen", o_rd_wen, 0);
    check("idle_rsp.rd_wdata", o_rd_wdata, 32'h0000_0BAD);
    check("idle_rsp.req_vld", dbus.o_dbus_req_vld, 0);

    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        passthrough($sformatf("rp%0d", n), 1'($urandom), 5'($urandom), $urandom);
      end else begin
        rv = '0;
        rv.wr = (kind >= 6);
        rv.rd = (kind < 6) || (kind == 9);
        rv.f3 = rv.wr ? 3'($urandom_range(0, 3)) : ld_f3s[$urandom_range(0, 9)];
        rv.addr = $urandom; rv.wdata = $urandom; rv.rdata = $urandom;
        rv.rd_wen = 1'($urandom); rv.rd_a = 5'($urandom);
        rv.rdy_dly = $urandom_range(0, 2); rv.rsp_dly = $urandom_range(0, 2);
        run_op(model(rv), $sformatf("r%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
